// File: rtl/sun_pll_lock_ctrl.sv
// sun_pll_lock_ctrl: start-up sequencer and lock monitor
// for the SUN_PLL charge-pump PLL (1.8 V domain).
module sun_pll_lock_ctrl #(
  parameter int T_BIAS   = 16,
  parameter int T_SETTLE = 256,
  parameter int WIN      = 512,
  parameter int EXP_CNT  = 16,
  parameter int TOL      = 1,
  parameter int N_GOOD   = 2,
  parameter int N_BAD    = 2,
  parameter int MAX_TRY  = 8
) (
  input  logic       CK_REF,
  input  logic       RST,
  input  logic       EN,
  input  logic       FB_DIV,
  output logic       PWRUP_BIAS,
  output logic       PWRUP_1V8,
  output logic       CK_EN,
  output logic       LOCK,
  output logic       LOCK_FAIL,
  output logic [2:0] STATE
);

  localparam int WW = $clog2(WIN);
  localparam int CW = $clog2(EXP_CNT + TOL + 2);
  localparam int NW = $clog2(MAX_TRY + N_GOOD + N_BAD + 1);

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    BIAS    = 3'd1,
    RAMP    = 3'd2,
    MEASURE = 3'd3,
    LOCKED  = 3'd4,
    FAIL    = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   timer_q;
  logic [WW-1:0] win_q;
  logic [CW-1:0] ecnt_q, cnt_tot;
  logic [NW-1:0] good_q, bad_q, try_q;
  logic [2:0]    sync_q;
  logic          fb_rise, meas, win_end;
  logic          win_good, timer_zero;
  logic          bias_d, v18_d, cken_d;
  logic          lock_d, fail_d;

  // closing-window count includes an edge in the end cycle
  assign fb_rise    = sync_q[1] & ~sync_q[2];
  assign meas       = (state_q == MEASURE) ||
                      (state_q == LOCKED);
  assign win_end    = meas && (win_q == WW'(WIN - 1));
  assign cnt_tot    = (&ecnt_q) ? ecnt_q
                                : ecnt_q + CW'(fb_rise);
  assign win_good   = (cnt_tot >= CW'(EXP_CNT - TOL)) &&
                      (cnt_tot <= CW'(EXP_CNT + TOL));
  assign timer_zero = (timer_q == '0);

  // FB_DIV synchronizer plus edge-detect flop
  always_ff @(posedge CK_REF) begin
    if (RST) sync_q <= '0;
    else     sync_q <= {sync_q[1:0], FB_DIV};
  end

  // state register
  always_ff @(posedge CK_REF) begin
    if (RST) state_q <= OFF;
    else     state_q <= state_d;
  end

  // next-state logic; EN low wins from any state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OFF:     state_d = BIAS;
      BIAS:    if (timer_zero) state_d = RAMP;
      RAMP:    if (timer_zero) state_d = MEASURE;
      MEASURE: begin
        if (win_end) begin
          if (win_good &&
              good_q == NW'(N_GOOD - 1))
            state_d = LOCKED;
          else if (!win_good &&
                   try_q == NW'(MAX_TRY - 1))
            state_d = FAIL;
        end
      end
      LOCKED: begin
        if (win_end && !win_good &&
            bad_q == NW'(N_BAD - 1))
          state_d = MEASURE;
      end
      FAIL:    state_d = FAIL;
      default: state_d = OFF;
    endcase
    if (!EN) state_d = OFF;
  end

  // output decode of the upcoming state
  always_comb begin
    bias_d = 1'b0;
    v18_d  = 1'b0;
    cken_d = 1'b0;
    lock_d = 1'b0;
    fail_d = 1'b0;
    unique case (state_d)
      BIAS: bias_d = 1'b1;
      RAMP, MEASURE: begin
        bias_d = 1'b1;
        v18_d  = 1'b1;
      end
      LOCKED: begin
        bias_d = 1'b1;
        v18_d  = 1'b1;
        cken_d = 1'b1;
        lock_d = 1'b1;
      end
      FAIL: begin
        bias_d = 1'b1;
        fail_d = 1'b1;
      end
      default: ;
    endcase
  end

  // registered outputs, aligned with state_q
  always_ff @(posedge CK_REF) begin
    if (RST) begin
      PWRUP_BIAS <= 1'b0;
      PWRUP_1V8  <= 1'b0;
      CK_EN      <= 1'b0;
      LOCK       <= 1'b0;
      LOCK_FAIL  <= 1'b0;
      STATE      <= 3'd0;
    end else begin
      PWRUP_BIAS <= bias_d;
      PWRUP_1V8  <= v18_d;
      CK_EN      <= cken_d;
      LOCK       <= lock_d;
      LOCK_FAIL  <= fail_d;
      STATE      <= state_d;
    end
  end

  // timer, window, edge and verdict counters
  always_ff @(posedge CK_REF) begin
    if (RST || state_d == OFF) begin
      timer_q <= '0;
      win_q   <= '0;
      ecnt_q  <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      try_q   <= '0;
    end else begin
      if (state_q != BIAS && state_d == BIAS)
        timer_q <= 16'(T_BIAS - 1);
      else if (state_q == BIAS && state_d == RAMP)
        timer_q <= 16'(T_SETTLE - 1);
      else if (!timer_zero)
        timer_q <= timer_q - 16'd1;

      if (!meas || win_end) begin
        win_q  <= '0;
        ecnt_q <= '0;
      end else begin
        win_q  <= win_q + WW'(1);
        ecnt_q <= cnt_tot;
      end

      if (state_q == RAMP) begin
        good_q <= '0;
        bad_q  <= '0;
        try_q  <= '0;
      end else if (win_end) begin
        if (state_q == MEASURE) begin
          bad_q <= '0;
          if (win_good) begin
            good_q <= good_q + NW'(1);
          end else begin
            good_q <= '0;
            try_q  <= try_q + NW'(1);
          end
        end else if (state_d == MEASURE) begin
          good_q <= '0;
          bad_q  <= '0;
          try_q  <= '0;
        end else if (win_good) begin
          bad_q <= '0;
        end else begin
          bad_q <= bad_q + NW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_sun_pll_lock_ctrl.sv
// tb_sun_pll_lock_ctrl: scenario tables feed a
// checkpoint scoreboard for sun_pll_lock_ctrl.
module tb_sun_pll_lock_ctrl;

  logic       CK_REF = 1'b0;
  logic       RST, EN, FB_DIV;
  logic       PWRUP_BIAS, PWRUP_1V8, CK_EN;
  logic       LOCK, LOCK_FAIL;
  logic [2:0] STATE;

  always #5 CK_REF = ~CK_REF;

  sun_pll_lock_ctrl dut (
    .CK_REF     (CK_REF),
    .RST        (RST),
    .EN         (EN),
    .FB_DIV     (FB_DIV),
    .PWRUP_BIAS (PWRUP_BIAS),
    .PWRUP_1V8  (PWRUP_1V8),
    .CK_EN      (CK_EN),
    .LOCK       (LOCK),
    .LOCK_FAIL  (LOCK_FAIL),
    .STATE      (STATE)
  );

  // {bias, 1v8, ck_en, lock, fail, state[2:0]}
  localparam logic [7:0] X_OFF  = 8'b00000_000;
  localparam logic [7:0] X_BIAS = 8'b10000_001;
  localparam logic [7:0] X_RAMP = 8'b11000_010;
  localparam logic [7:0] X_MEAS = 8'b11000_011;
  localparam logic [7:0] X_LOCK = 8'b11110_100;
  localparam logic [7:0] X_FAIL = 8'b10001_101;

  // first window cycle ends at edge 1+16+256+1
  localparam int W0 = 274;

  typedef logic [8*14-1:0] tag_t;

  typedef struct {
    int         scn;
    int         cyc;
    logic [7:0] exp;
    tag_t       name;
  } chk_t;

  typedef struct {
    int per;
    int en_off;
    int en_on;
    int ncyc;
  } scn_t;

  typedef struct {
    int scn;
    int k;
    int sp;
    bit bnd;
  } win_t;

  chk_t chk_tab[$];
  scn_t scn_tab[$];
  win_t win_tab[$];
  chk_t sb[$];
  win_t wins[$];
  scn_t cur;
  int   cyc;
  int   n_chk;
  int   n_fail;

  // FB_DIV level sampled at edge n; its edge
  // pulse lands in the cycle ending at n+2
  function automatic logic fb_at(int n);
    int e, w, o;
    if (cur.per > 0)
      return ((n / (cur.per / 2)) % 2) == 1;
    e = n + 2;
    if (e < W0) return 1'b0;
    w = (e - W0) / 512;
    o = (e - W0) % 512;
    if (w >= wins.size()) return 1'b0;
    if (wins[w].bnd && o == 511) return 1'b1;
    if (o < 4) return 1'b0;
    return ((o - 4) % wins[w].sp < wins[w].sp / 2)
        && ((o - 4) / wins[w].sp < wins[w].k);
  endfunction

  task automatic compare(input tag_t nm,
                         input logic [7:0] exp);
    logic [7:0] act;
    act = {PWRUP_BIAS, PWRUP_1V8, CK_EN,
           LOCK, LOCK_FAIL, STATE};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s cyc=%0d got=%b need=%b",
               nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    RST    = 1'b1;
    EN     = 1'b1;
    FB_DIV = 1'b0;
    repeat (3) begin
      @(posedge CK_REF);
      #1;
      compare("reset", X_OFF);
    end
    RST = 1'b0;
    cyc = 0;
  endtask

  task automatic step();
    int   n;
    chk_t c;
    n      = cyc + 1;
    FB_DIV = fb_at(n);
    EN     = !(cur.en_off != 0 && n >= cur.en_off &&
               (cur.en_on == 0 || n < cur.en_on));
    @(posedge CK_REF);
    #1;
    cyc = n;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      c = sb.pop_front();
      compare(c.name, c.exp);
    end
  endtask

  task automatic run_scn(input int s);
    cur = scn_tab[s];
    wins.delete();
    sb.delete();
    foreach (win_tab[i])
      if (win_tab[i].scn == s) wins.push_back(win_tab[i]);
    foreach (chk_tab[i])
      if (chk_tab[i].scn == s) sb.push_back(chk_tab[i]);
    do_reset();
    for (int i = 0; i < cur.ncyc; i++) step();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain scn=%0d left=%0d need=0",
               s, sb.size());
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    RST    = 1'b1;
    EN     = 1'b0;
    FB_DIV = 1'b0;

    // per, en_off, en_on, ncyc
    scn_tab.push_back('{32, 1400, 0, 1405});
    scn_tab.push_back('{0, 100, 0, 105});
    scn_tab.push_back('{0, 0, 0, 2325});
    scn_tab.push_back('{0, 4371, 4372, 4390});
    scn_tab.push_back('{0, 0, 0, 1300});
    scn_tab.push_back('{0, 0, 0, 1300});
    scn_tab.push_back('{2, 0, 0, 1300});

    // scn, edges, spacing, boundary edge
    win_tab.push_back('{2, 15, 28, 1'b0});
    win_tab.push_back('{2, 17, 28, 1'b0});
    win_tab.push_back('{2, 14, 28, 1'b0});
    win_tab.push_back('{2, 14, 28, 1'b0});
    win_tab.push_back('{4, 14, 28, 1'b1});
    win_tab.push_back('{4, 15, 28, 1'b0});
    win_tab.push_back('{5, 48, 10, 1'b0});
    win_tab.push_back('{5, 48, 10, 1'b0});

    chk_tab.push_back('{0, 1, X_BIAS, "bias_on"});
    chk_tab.push_back('{0, 16, X_BIAS, "bias_hold"});
    chk_tab.push_back('{0, 17, X_RAMP, "pwrup_1v8"});
    chk_tab.push_back('{0, 272, X_RAMP, "ramp_hold"});
    chk_tab.push_back('{0, 273, X_MEAS, "measure"});
    chk_tab.push_back('{0, 1296, X_MEAS, "prelock"});
    chk_tab.push_back('{0, 1297, X_LOCK, "lock"});
    chk_tab.push_back('{0, 1399, X_LOCK, "lock_hold"});
    chk_tab.push_back('{0, 1400, X_OFF, "drop_locked"});
    chk_tab.push_back('{1, 1, X_BIAS, "bias_on2"});
    chk_tab.push_back('{1, 99, X_RAMP, "ramp_mid"});
    chk_tab.push_back('{1, 100, X_OFF, "drop_ramp"});
    chk_tab.push_back('{1, 104, X_OFF, "off_stay"});
    chk_tab.push_back('{2, 785, X_MEAS, "tol_w1"});
    chk_tab.push_back('{2, 1296, X_MEAS, "tol_prelock"});
    chk_tab.push_back('{2, 1297, X_LOCK, "tol_lock"});
    chk_tab.push_back('{2, 1809, X_LOCK, "tol_bad1"});
    chk_tab.push_back('{2, 2320, X_LOCK, "tol_predrop"});
    chk_tab.push_back('{2, 2321, X_MEAS, "tol_drop"});
    chk_tab.push_back('{3, 4368, X_MEAS, "fail_pre"});
    chk_tab.push_back('{3, 4369, X_FAIL, "fail"});
    chk_tab.push_back('{3, 4370, X_FAIL, "fail_hold"});
    chk_tab.push_back('{3, 4371, X_OFF, "fail_off"});
    chk_tab.push_back('{3, 4372, X_BIAS, "restart"});
    chk_tab.push_back('{3, 4387, X_BIAS, "restart_bias"});
    chk_tab.push_back('{3, 4388, X_RAMP, "restart_ramp"});
    chk_tab.push_back('{4, 785, X_MEAS, "bnd_w1"});
    chk_tab.push_back('{4, 1297, X_LOCK, "bnd_lock"});
    chk_tab.push_back('{5, 785, X_MEAS, "sat_w1"});
    chk_tab.push_back('{5, 1297, X_MEAS, "sat_nolock"});
    chk_tab.push_back('{6, 1297, X_MEAS, "fast_nolock"});

    for (int s = 0; s < scn_tab.size(); s++) run_scn(s);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
